// File: rtl/cache_mem_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the data-cache memory-side controller.
package cache_mem_ctrl_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int WBUF_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FILL = 2'd3
  } state_e;

endpackage

// File: rtl/cache_mem_ctrl_wbuf.sv
// Write-through store buffer: circular FIFO with oldest-first head and youngest-match lookup.
// Push/pop take effect on the clock edge; full comes from the registered count, so the producer must respect it.
module cache_mem_ctrl_wbuf
  import cache_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = WBUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              match_any,
  output logic [DATA_W-1:0] match_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Walk entries oldest to youngest so the last hit left standing is the youngest store.
  always_comb begin
    match_any  = 1'b0;
    match_data = '0;
    idx        = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_mem[idx] == lookup_addr)) begin
        match_any  = 1'b1;
        match_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side cache controller: read-miss fills plus buffered write-through drain (WBUF_FWD_EN forwards buffered stores).
// Miss: mem_req the cycle after accept, fill_valid the cycle after mem_ack; stores stall only when the buffer is full.
module cache_mem_ctrl
  import cache_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef WBUF_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  state_e            state;
  state_e            state_next;
  logic              wb_full;
  logic              wb_empty;
  logic              wb_match;
  logic [ADDR_W-1:0] wb_head_addr;
  logic [DATA_W-1:0] wb_head_data;
  logic [DATA_W-1:0] wb_match_data;
  logic              push;
  logic              pop;

  assign wr_ready   = ~wb_full;
  assign push       = wr_req & wr_ready;
  assign pop        = (state == ST_WR) & mem_ack;
  assign fill_valid = (state == ST_FILL);
  assign busy       = miss_req & ~fill_valid;

  cache_mem_ctrl_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (wr_addr),
    .push_data   (wr_data),
    .pop         (pop),
    .lookup_addr (miss_addr),
    .full        (wb_full),
    .empty       (wb_empty),
    .head_addr   (wb_head_addr),
    .head_data   (wb_head_data),
    .match_any   (wb_match),
    .match_data  (wb_match_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_addr <= '0;
      fill_data <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && miss_req) fill_addr <= miss_addr;
      if (state == ST_IDLE && miss_req && wb_match && FWD_EN) fill_data <= wb_match_data;
      if (state == ST_RD && mem_ack) fill_data <= mem_rdata;
    end
  end

  // A miss to an address still in the buffer must not overtake that store in memory.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        if (miss_req && !wb_match)    state_next = ST_RD;
        else if (miss_req && FWD_EN)  state_next = ST_FILL;
        else if (!wb_empty)           state_next = ST_WR;
      end
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = miss_addr;
        if (mem_ack) state_next = ST_FILL;
      end
      ST_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_head_addr;
        mem_wdata = wb_head_data;
        if (mem_ack) state_next = ST_IDLE;
      end
      ST_FILL: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: scripted memory responder, transaction log, hand-computed expectations.
module tb_cache_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [7:0]  miss_addr;
  logic        fill_valid;
  logic [7:0]  fill_addr;
  logic [15:0] fill_data;
  logic        busy;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  cache_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data), .busy(busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] mem_model [256];
  int          ack_delay = 1;
  logic        log_we   [$];
  logic [7:0]  log_addr [$];
  logic [15:0] log_data [$];
  int          fill_cnt = 0;
  logic [7:0]  last_fill_addr = '0;
  logic [15:0] last_fill_data = '0;

  // Memory: acks after ack_delay cycles of mem_req, records every completed transaction.
  initial begin : responder
    int waited;
    waited    = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        waited++;
        if (waited >= ack_delay) begin
          mem_ack = 1'b1;
          waited  = 0;
          log_we.push_back(mem_we);
          log_addr.push_back(mem_addr);
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            log_data.push_back(mem_wdata);
            mem_rdata = '0;
          end else begin
            mem_rdata = mem_model[mem_addr];
            log_data.push_back(mem_rdata);
          end
        end
      end else begin
        mem_ack = 1'b0;
        waited  = 0;
      end
    end
  end

  initial begin : fill_monitor
    forever begin
      @(negedge clk);
      if (fill_valid === 1'b1) begin
        fill_cnt++;
        last_fill_addr = fill_addr;
        last_fill_data = fill_data;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Packed log entry {we, addr, data}; out-of-range reads give a value no entry can take.
  function automatic logic [31:0] lg(input int i);
    if (i >= log_we.size()) return 32'hFFFF_FFFF;
    return {7'b0, log_we[i], log_addr[i], log_data[i]};
  endfunction

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_fill(input int start);
    for (int i = 0; i < 60 && fill_cnt == start; i++) tick();
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 80 && log_we.size() < n; i++) tick();
    repeat (3) tick();
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] d, output logic rdy_first);
    wr_req    = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    rdy_first = wr_ready;
    for (int i = 0; i < 80 && !wr_ready; i++) tick();
    tick();
    wr_req = 1'b0;
  endtask

  initial begin : main
    logic rdy;
    int   start;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) tick();
    check("reset_fill_data", fill_data, 16'h0000);
    check("reset_mem_addr", mem_addr, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_mem_req", mem_req, 1'b0);
      check("idle_wr_ready", wr_ready, 1'b1);
      check("idle_fill_valid", fill_valid, 1'b0);
    end

    // Plain read miss, memory acks after 3 cycles.
    mem_model[8'h12] = 16'hBEEF;
    ack_delay = 3;
    clear_log();
    start = fill_cnt;
    miss_req = 1'b1; miss_addr = 8'h12;
    check("miss_busy", busy, 1'b1);
    tick();
    check("miss_req_next", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h12});
    wait_fill(start);
    miss_req = 1'b0;
    check("miss_fill_data", last_fill_data, 16'hBEEF);
    check("miss_fill_addr", last_fill_addr, 8'h12);
    wait_log(1);
    check("miss_fill_count", fill_cnt, start + 1);
    check("miss_log_size", log_we.size(), 1);
    check("miss_log0", lg(0), 32'h0012_BEEF);

    // Three back-to-back stores with slow memory fill the 2-entry buffer.
    ack_delay = 4;
    clear_log();
    store(8'h04, 16'h1111, rdy);
    check("st1_ready", rdy, 1'b1);
    store(8'h05, 16'h2222, rdy);
    check("st2_ready", rdy, 1'b1);
    store(8'h06, 16'h3333, rdy);
    check("st3_ready_low", rdy, 1'b0);
    wait_log(3);
    check("st_log_size", log_we.size(), 3);
    check("st_log0", lg(0), 32'h0104_1111);
    check("st_log1", lg(1), 32'h0105_2222);
    check("st_log2", lg(2), 32'h0106_3333);
    check("st_drained_ready", wr_ready, 1'b1);
    check("st_drained_req", mem_req, 1'b0);

    // Miss to an address with a buffered store.
    ack_delay = 2;
    clear_log();
    start = fill_cnt;
    store(8'h20, 16'hAAAA, rdy);
    miss_req = 1'b1; miss_addr = 8'h20;
`ifdef WBUF_FWD_EN
    tick();
    check("fwd_latency", fill_cnt, start + 1);
`endif
    wait_fill(start);
    miss_req = 1'b0;
    check("hit_fill_data", last_fill_data, 16'hAAAA);
    check("hit_fill_addr", last_fill_addr, 8'h20);
`ifdef WBUF_FWD_EN
    wait_log(1);
    check("fwd_log_size", log_we.size(), 1);
    check("fwd_log0", lg(0), 32'h0120_AAAA);
`else
    wait_log(2);
    check("ord_log_size", log_we.size(), 2);
    check("ord_log0", lg(0), 32'h0120_AAAA);
    check("ord_log1", lg(1), 32'h0020_AAAA);
`endif

    // Miss to a different address takes priority over draining the buffer.
    ack_delay = 1;
    mem_model[8'h30] = 16'h5A5A;
    clear_log();
    start = fill_cnt;
    store(8'h31, 16'h3131, rdy);
    miss_req = 1'b1; miss_addr = 8'h30;
    wait_fill(start);
    miss_req = 1'b0;
    check("prio_fill_data", last_fill_data, 16'h5A5A);
    check("prio_fill_addr", last_fill_addr, 8'h30);
    wait_log(2);
    check("prio_log0", lg(0), 32'h0030_5A5A);
    check("prio_log1", lg(1), 32'h0131_3131);

    // Reset while a read is outstanding, with a store still buffered.
    ack_delay = 1000;
    clear_log();
    start = fill_cnt;
    store(8'h41, 16'h4141, rdy);
    miss_req = 1'b1; miss_addr = 8'h40;
    tick();
    check("rst_pre_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h40});
    rst = 1'b1; miss_req = 1'b0;
    tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_fill_valid", fill_valid, 1'b0);
    rst = 1'b0;
    ack_delay = 1;
    repeat (6) tick();
    check("rst_no_drain", mem_req, 1'b0);
    check("rst_no_fill", fill_cnt, start);
    check("rst_log_size", log_we.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
